// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage <-> hazard scoreboard bundle.
//   master : ID-stage control (drives hold/flush and the decoded ID instruction)
//   slave  : hazard_scoreboard (returns stall, EX forward selects, stall count)
// Ports carried: hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en,
//   id_wr_reg, id_is_load, id_is_store, stall, fwd_a, fwd_b, fwd_st, stall_cnt.
interface hazard_scoreboard_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned FSEL_W = $clog2(DEPTH + 1);

  logic              hold;
  logic              flush;
  logic              id_valid;
  logic [AW-1:0]     id_rs;
  logic [AW-1:0]     id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wr_en;
  logic [AW-1:0]     id_wr_reg;
  logic              id_is_load;
  logic              id_is_store;
  logic              stall;
  logic [FSEL_W-1:0] fwd_a;
  logic [FSEL_W-1:0] fwd_b;
  logic              fwd_st;
  logic [15:0]       stall_cnt;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
           id_is_load, id_is_store,
    input  stall, fwd_a, fwd_b, fwd_st, stall_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_reg,
           id_is_load, id_is_store,
    output stall, fwd_a, fwd_b, fwd_st, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard detection and EX forwarding-select generation.
// Tracks the destination of every in-flight instruction in a DEPTH-slot shift register
// (slot 1 = EX, slot 2 = MEM, ...). Produces a combinational stall for ID and registered
// operand selects (0 = register file, k = result k slots ahead of EX).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   sb    : hazard_scoreboard_if.slave (hold, flush, ID instruction in; stall, fwd_a,
//           fwd_b, fwd_st, stall_cnt out)
// Optional feature: define HAZARD_STORE_FWD_EN to let a store's data operand take a load
// result late (WB -> MEM) instead of stalling; otherwise fwd_st is tied to 0.
module hazard_scoreboard #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  hazard_scoreboard_if.slave sb
);
  localparam int unsigned FSEL_W = $clog2(DEPTH + 1);
  typedef logic [FSEL_W-1:0] fsel_t;
  localparam fsel_t LoadLatSel = fsel_t'(LOAD_LAT);

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rg;
    logic          ld;
  } slot_t;

  slot_t [DEPTH:1] slot_q, slot_d;
  fsel_t           fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic            fwd_st_q, fwd_st_d;
  logic [15:0]     cnt_q, cnt_d;

  logic  rs_hit, rt_hit, rs_ld, rt_ld;
  fsel_t rs_k, rt_k;
  logic  rs_dep, rt_dep, haz_rs, haz_rt, st_fwd;
  logic  stall, issue;

  // Scan oldest to youngest so the lowest matching slot (youngest producer) wins.
  always_comb begin
    rs_hit = 1'b0;
    rs_ld  = 1'b0;
    rs_k   = '0;
    rt_hit = 1'b0;
    rt_ld  = 1'b0;
    rt_k   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (slot_q[k].v && (slot_q[k].rg == sb.id_rs)) begin
        rs_hit = 1'b1;
        rs_ld  = slot_q[k].ld;
        rs_k   = fsel_t'(k);
      end
      if (slot_q[k].v && (slot_q[k].rg == sb.id_rt)) begin
        rt_hit = 1'b1;
        rt_ld  = slot_q[k].ld;
        rt_k   = fsel_t'(k);
      end
    end
  end

  assign rs_dep = sb.id_use_rs && (sb.id_rs != '0) && rs_hit;
  assign rt_dep = sb.id_use_rt && (sb.id_rt != '0) && rt_hit;

`ifdef HAZARD_STORE_FWD_EN
  // Store data is needed one stage later than a normal operand, so a load that is one
  // cycle short of forwardable can still feed it from WB into MEM.
  assign st_fwd = sb.id_is_store && rt_dep && rt_ld && (rt_k >= LoadLatSel);
`else
  logic unused_store;
  assign unused_store = sb.id_is_store;
  assign st_fwd       = 1'b0;
`endif

  assign haz_rs = rs_dep && rs_ld && (rs_k <= LoadLatSel);
  assign haz_rt = rt_dep && rt_ld && (rt_k <= LoadLatSel) && !st_fwd;
  assign stall  = sb.id_valid && (haz_rs || haz_rt) && !sb.flush;
  assign issue  = sb.id_valid && !stall && !sb.hold && !sb.flush;

  always_comb begin
    slot_d   = slot_q;
    fwd_a_d  = fwd_a_q;
    fwd_b_d  = fwd_b_q;
    fwd_st_d = fwd_st_q;
    cnt_d    = cnt_q;
    // hold freezes everything; a concurrent flush is deferred by upstream until hold drops.
    if (!sb.hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        slot_d[k] = slot_q[k-1];
      end
      slot_d[1].v  = issue && sb.id_wr_en && (sb.id_wr_reg != '0);
      slot_d[1].rg = sb.id_wr_reg;
      slot_d[1].ld = sb.id_is_load;
      // Kill the instruction moving out of EX.
      if (sb.flush) begin
        slot_d[2].v = 1'b0;
      end
      fwd_a_d  = (issue && rs_dep) ? rs_k : '0;
      fwd_b_d  = (issue && rt_dep && !st_fwd) ? rt_k : '0;
      fwd_st_d = issue && st_fwd;
      if (stall && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q   <= '0;
      fwd_a_q  <= '0;
      fwd_b_q  <= '0;
      fwd_st_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      slot_q   <= slot_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
      fwd_st_q <= fwd_st_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sb.stall     = stall;
  assign sb.fwd_a     = fwd_a_q;
  assign sb.fwd_b     = fwd_b_q;
  assign sb.fwd_st    = fwd_st_q;
  assign sb.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: dut0 uses DEPTH=3/LOAD_LAT=1, dut1 uses
// DEPTH=5/LOAD_LAT=3. Inputs are shared; sel steers id_valid to one DUT at a time.
module tb_hazard_scoreboard;
  logic       clk, reset, sel;
  logic       hold, flush, id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_store;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  int         checks, failures, exp_cnt;

  hazard_scoreboard_if #(.AW(5), .DEPTH(3)) sb0 ();
  hazard_scoreboard_if #(.AW(5), .DEPTH(5)) sb1 ();

  assign sb0.hold        = hold;
  assign sb0.flush       = flush;
  assign sb0.id_valid    = id_valid && !sel;
  assign sb0.id_rs       = id_rs;
  assign sb0.id_rt       = id_rt;
  assign sb0.id_use_rs   = id_use_rs;
  assign sb0.id_use_rt   = id_use_rt;
  assign sb0.id_wr_en    = id_wr_en;
  assign sb0.id_wr_reg   = id_wr_reg;
  assign sb0.id_is_load  = id_is_load;
  assign sb0.id_is_store = id_is_store;
  assign sb1.hold        = hold;
  assign sb1.flush       = flush;
  assign sb1.id_valid    = id_valid && sel;
  assign sb1.id_rs       = id_rs;
  assign sb1.id_rt       = id_rt;
  assign sb1.id_use_rs   = id_use_rs;
  assign sb1.id_use_rt   = id_use_rt;
  assign sb1.id_wr_en    = id_wr_en;
  assign sb1.id_wr_reg   = id_wr_reg;
  assign sb1.id_is_load  = id_is_load;
  assign sb1.id_is_store = id_is_store;

  hazard_scoreboard #(.AW(5), .DEPTH(3), .LOAD_LAT(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .sb    (sb0.slave)
  );

  hazard_scoreboard #(.AW(5), .DEPTH(5), .LOAD_LAT(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .sb    (sb1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID instruction: valid, rs, rt, use_rs, use_rt, wr_en, wr_reg, load, store.
  task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                    input logic urs, input logic urt, input logic we,
                    input logic [4:0] wr, input logic ld, input logic st);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr_en = we; id_wr_reg = wr; id_is_load = ld; id_is_store = st;
    #1;
  endtask

  task automatic idle(input int n);
    id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks = 0; failures = 0; exp_cnt = 0; sel = 1'b0;
    // Reset with random inputs
    reset = 1'b0; hold = 1'($urandom); flush = 1'($urandom);
    id(1, 5'($urandom), 5'($urandom), 1, 1, 1, 5'($urandom), 1'($urandom), 1'($urandom));
    #2;
    chk("rst_stall", 32'(sb0.stall), 0);
    chk("rst_fwd_a", 32'(sb0.fwd_a), 0);
    chk("rst_fwd_b", 32'(sb0.fwd_b), 0);
    chk("rst_cnt", 32'(sb0.stall_cnt), 0);
    tick();
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    idle(1);

    // ALU chain: add r3<-r1,r2; sub r4<-r3,r3; or r5<-r3,r0
    id(1, 1, 2, 1, 1, 1, 3, 0, 0);
    chk("alu_add_stall", 32'(sb0.stall), 0);
    tick();
    id(1, 3, 3, 1, 1, 1, 4, 0, 0);
    chk("alu_sub_stall", 32'(sb0.stall), 0);
    tick();
    chk("alu_sub_fwd_a", 32'(sb0.fwd_a), 1);
    chk("alu_sub_fwd_b", 32'(sb0.fwd_b), 1);
    id(1, 3, 0, 1, 1, 1, 5, 0, 0);
    chk("alu_or_stall", 32'(sb0.stall), 0);
    tick();
    chk("alu_or_fwd_a", 32'(sb0.fwd_a), 2);
    chk("alu_or_fwd_b", 32'(sb0.fwd_b), 0);
    idle(1);
    chk("bubble_fwd_a", 32'(sb0.fwd_a), 0);
    idle(3);

    // Load-use, LOAD_LAT=1: lw r8; add r9<-r8,r1
    id(1, 1, 0, 1, 0, 1, 8, 1, 0);
    tick();
    id(1, 8, 1, 1, 1, 1, 9, 0, 0);
    chk("lu_stall1", 32'(sb0.stall), 1);
    tick(); exp_cnt++;
    chk("lu_stall_done", 32'(sb0.stall), 0);
    tick();
    chk("lu_fwd_a", 32'(sb0.fwd_a), 2);
    chk("lu_fwd_b", 32'(sb0.fwd_b), 0);
    chk("lu_cnt", 32'(sb0.stall_cnt), 32'(exp_cnt));
    idle(3);

    // Youngest wins: lw r2; add r2<-r2,r2; add r6<-r2,r0
    id(1, 1, 0, 1, 0, 1, 2, 1, 0);
    tick();
    id(1, 2, 2, 1, 1, 1, 2, 0, 0);
    chk("yw_stall", 32'(sb0.stall), 1);
    tick(); exp_cnt++;
    tick();
    chk("yw_add1_fwd_a", 32'(sb0.fwd_a), 2);
    id(1, 2, 0, 1, 1, 1, 6, 0, 0);
    chk("yw_add2_stall", 32'(sb0.stall), 0);
    tick();
    chk("yw_add2_fwd_a", 32'(sb0.fwd_a), 1);
    chk("yw_add2_fwd_b", 32'(sb0.fwd_b), 0);
    idle(3);

    // Flush: lw r7 in EX, dependent in ID squashed
    id(1, 1, 0, 1, 0, 1, 7, 1, 0);
    tick();
    flush = 1'b1;
    id(1, 7, 1, 1, 1, 1, 12, 0, 0);
    chk("fl_stall", 32'(sb0.stall), 0);
    tick();
    flush = 1'b0;
    chk("fl_fwd_a", 32'(sb0.fwd_a), 0);
    id(1, 7, 7, 1, 1, 1, 13, 0, 0);
    chk("fl_next_stall", 32'(sb0.stall), 0);
    tick();
    chk("fl_next_fwd_a", 32'(sb0.fwd_a), 0);
    chk("fl_next_fwd_b", 32'(sb0.fwd_b), 0);
    chk("fl_cnt", 32'(sb0.stall_cnt), 32'(exp_cnt));
    idle(3);

    // Hold mid-stall: add r14<-r0,r0; lw r8,0(r14); add r9<-r8,r1 with 4 hold cycles
    id(1, 0, 0, 1, 1, 1, 14, 0, 0);
    tick();
    id(1, 14, 0, 1, 0, 1, 8, 1, 0);
    tick();
    chk("hd_lw_fwd_a", 32'(sb0.fwd_a), 1);
    hold = 1'b1;
    id(1, 8, 1, 1, 1, 1, 9, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hd_stall", 32'(sb0.stall), 1);
      chk("hd_fwd_a", 32'(sb0.fwd_a), 1);
      chk("hd_cnt", 32'(sb0.stall_cnt), 32'(exp_cnt));
    end
    hold = 1'b0;
    #1;
    chk("hd_release_stall", 32'(sb0.stall), 1);
    tick(); exp_cnt++;
    chk("hd_bubble_fwd_a", 32'(sb0.fwd_a), 0);
    chk("hd_cnt_after", 32'(sb0.stall_cnt), 32'(exp_cnt));
    chk("hd_stall_done", 32'(sb0.stall), 0);
    tick();
    chk("hd_dep_fwd_a", 32'(sb0.fwd_a), 2);
    idle(3);

    // Store forwarding: lw r10; sw r10,0(r11)
    id(1, 1, 0, 1, 0, 1, 10, 1, 0);
    tick();
    id(1, 11, 10, 1, 1, 0, 0, 0, 1);
`ifdef HAZARD_STORE_FWD_EN
    chk("sf_stall", 32'(sb0.stall), 0);
    tick();
    chk("sf_fwd_b", 32'(sb0.fwd_b), 0);
    chk("sf_fwd_st", 32'(sb0.fwd_st), 1);
`else
    chk("sf_stall", 32'(sb0.stall), 1);
    tick(); exp_cnt++;
    chk("sf_stall_done", 32'(sb0.stall), 0);
    tick();
    chk("sf_fwd_b", 32'(sb0.fwd_b), 2);
    chk("sf_fwd_st", 32'(sb0.fwd_st), 0);
`endif
    chk("sf_fwd_a", 32'(sb0.fwd_a), 0);
    chk("sf_cnt", 32'(sb0.stall_cnt), 32'(exp_cnt));
    idle(3);

    // Reset asserted mid-stall
    id(1, 1, 0, 1, 0, 1, 8, 1, 0);
    tick();
    id(1, 8, 1, 1, 1, 1, 9, 0, 0);
    chk("rm_stall", 32'(sb0.stall), 1);
    reset = 1'b0;
    #1;
    chk("rm_stall_rst", 32'(sb0.stall), 0);
    chk("rm_cnt_rst", 32'(sb0.stall_cnt), 0);
    reset = 1'b1;
    #1;
    chk("rm_stall_rel", 32'(sb0.stall), 0);
    tick();
    chk("rm_fwd_a", 32'(sb0.fwd_a), 0);
    idle(3);

    // DEPTH=5, LOAD_LAT=3: lw r8; add r9<-r8,r1
    sel = 1'b1;
    id(1, 1, 0, 1, 0, 1, 8, 1, 0);
    tick();
    id(1, 8, 1, 1, 1, 1, 9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("d5_stall", 32'(sb1.stall), 1);
      tick();
    end
    chk("d5_stall_done", 32'(sb1.stall), 0);
    tick();
    chk("d5_fwd_a", 32'(sb1.fwd_a), 4);
    chk("d5_cnt", 32'(sb1.stall_cnt), 3);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
